// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add multiply,
// restoring divide, fast path for divide-by-zero and signed overflow.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              s1_q, s1_d;      // op1 was negative (signed operand only)
    logic              s2_q, s2_d;      // op2 was negative (signed operand only)
    logic [XLEN-1:0]   a_q, a_d;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;    // product, or {remainder, quotient}
    logic [XLEN-1:0]   res_q, res_d;

    // Operand decode at the request port.
    logic            is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2;

    assign is_div   = i_op[2];
    assign sgn1     = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
    assign sgn2     = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);
    assign neg1     = sgn1 && i_op1[XLEN-1];
    assign neg2     = sgn2 && i_op2[XLEN-1];
    assign mag1     = neg1 ? ({XLEN{1'b0}} - i_op1) : i_op1;
    assign mag2     = neg2 ? ({XLEN{1'b0}} - i_op2) : i_op2;
    assign div_zero = is_div && (i_op2 == {XLEN{1'b0}});
    assign div_ovf  = is_div && !i_op[0] && (i_op1 == INT_MIN) && (i_op2 == {XLEN{1'b1}});

    // One iteration of either algorithm on the held state.
    logic [XLEN:0]     add_sum, rem_sh, diff;
    logic [2*XLEN-1:0] mul_next, div_next, step;

    assign add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    assign mul_next = {add_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, a_q};
    assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
    assign step     = op_q[2] ? div_next : mul_next;

    // Sign fix-up and result selection on the final iteration's output.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    assign prod_fix = (s1_q ^ s2_q) ? ({(2*XLEN){1'b0}} - step) : step;
    assign quo_fix  = (s1_q ^ s2_q) ? ({XLEN{1'b0}} - step[XLEN-1:0]) : step[XLEN-1:0];
    assign rem_fix  = s1_q ? ({XLEN{1'b0}} - step[2*XLEN-1:XLEN]) : step[2*XLEN-1:XLEN];
    assign fix_res  = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                              : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    // Next-state logic: flush overrides everything, then the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        a_d     = a_q;
        acc_d   = acc_q;
        res_d   = res_q;
        if (i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        op_d = i_op;
                        s1_d = neg1;
                        s2_d = neg2;
                        if (div_zero) begin
                            res_d   = i_op[1] ? i_op1 : {XLEN{1'b1}};
                            state_d = S_DONE;
                        end else if (div_ovf) begin
                            res_d   = i_op[1] ? {XLEN{1'b0}} : i_op1;
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = CNT_W'(XLEN);
                            a_d     = is_div ? mag2 : mag1;
                            acc_d   = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_d = step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = fix_res;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            a_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_valid  = (state_q == S_DONE);
    assign o_busy   = (state_q != S_IDLE);
    assign o_result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (XLEN=32).
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op = 3'b000;
    logic [31:0] i_op1 = 32'h0;
    logic [31:0] i_op2 = 32'h0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_result;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one op with i_ready high, measure latency, check result and return to IDLE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        n = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
        end
        i_valid = 1'b1;
        i_op    = op;
        i_op1   = a;
        i_op2   = b;
        tick();
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_res"}, o_result, exp_res);
        tick();
        check({tag, "_valid_drop"}, {31'b0, o_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, o_ready}, 32'd1);
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state while i_rst_n is low.
        #2;
        check("rst_valid",  {31'b0, o_valid}, 32'd0);
        check("rst_ready",  {31'b0, o_ready}, 32'd1);
        check("rst_busy",   {31'b0, o_busy},  32'd0);
        check("rst_result", o_result, 32'd0);
        #10;
        i_rst_n = 1'b1;
        tick();

        // Reset pulled low mid-BUSY takes effect without a clock edge.
        i_valid = 1'b1; i_op = 3'b000; i_op1 = 32'd7; i_op2 = 32'd3;
        tick();
        i_valid = 1'b0;
        repeat (4) tick();
        check("midrst_busy_before", {31'b0, o_busy}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("midrst_valid",  {31'b0, o_valid}, 32'd0);
        check("midrst_ready",  {31'b0, o_ready}, 32'd1);
        check("midrst_busy",   {31'b0, o_busy},  32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();

        // Multiply family.
        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);

        // Divide family.
        run_op("div",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_op("rem",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_op("divu", 3'b101, 32'd100,      32'd7, 32'd14,       33);
        run_op("remu", 3'b111, 32'd100,      32'd7, 32'd2,        33);

        // Fast path: overflow and divide by zero.
        run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_op("divu_dz",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("remu_dz",  3'b111, 32'd5,        32'd0,        32'd5,        1);

        // Backpressure: hold result for 10 cycles with i_valid asserted meanwhile.
        i_ready = 1'b0;
        i_valid = 1'b1; i_op = 3'b101; i_op1 = 32'd100; i_op2 = 32'd7;
        tick();
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp_lat", n, 33);
        for (int k = 0; k < 10; k++) begin
            i_valid = 1'b1; i_op = 3'b000; i_op1 = 32'd1; i_op2 = 32'd1;
            tick();
            check("bp_hold_valid",  {31'b0, o_valid}, 32'd1);
            check("bp_hold_result", o_result, 32'd14);
            check("bp_hold_ready",  {31'b0, o_ready}, 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("bp_release_ready", {31'b0, o_ready}, 32'd1);
        check("bp_release_valid", {31'b0, o_valid}, 32'd0);
        tick();
        check("bp_not_queued", {31'b0, o_busy}, 32'd0);

        // Flush at BUSY cycle 12 together with a new request.
        i_valid = 1'b1; i_op = 3'b000; i_op1 = 32'd5; i_op2 = 32'd6;
        tick();
        i_valid = 1'b0;
        repeat (11) tick();
        check("flush_busy_before", {31'b0, o_busy}, 32'd1);
        i_flush = 1'b1;
        i_valid = 1'b1; i_op = 3'b000; i_op1 = 32'd9; i_op2 = 32'd9;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush_idle_busy",  {31'b0, o_busy},  32'd0);
        check("flush_idle_ready", {31'b0, o_ready}, 32'd1);
        check("flush_idle_valid", {31'b0, o_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (o_valid || o_busy) seen = 1'b1;
        end
        check("flush_no_activity", {31'b0, seen}, 32'd0);
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
